// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register select codes, FSM states and limits shared by the interrupt controller.
package irq_ctrl_pkg;
  localparam int MAX_SRC = 8;
  typedef enum logic [1:0] {REG_IE = 2'd0, REG_IF = 2'd1, REG_OVR = 2'd2, REG_RSVD = 2'd3} reg_sel_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_ACK = 2'd2} state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder, returns index and any-set flag.
module irq_prio_enc #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  output logic [2:0]   id,
  output logic         valid
);
  always_comb begin
    id = 3'd0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) id = 3'(i);
    valid = |req;
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-detecting interrupt controller with IE/IF registers and request/take CPU handshake.
// Define IRQ_CTRL_OVR_EN to add the sticky overrun register on reg_sel 2.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_SRC    = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic [1:0]         reg_sel,
  input  logic               reg_wr,
  input  logic [7:0]         reg_din,
  output logic [7:0]         reg_dout,
  output logic               int_pend,
  input  logic               int_take,
  output logic [2:0]         int_id,
  output logic [15:0]        int_vec
);
  typedef logic [NUM_SRC-1:0] src_t;
  src_t req_q, req_d, ie_q, ie_d, if_q, if_d, edge_v, act, take_mask, if_base;
  state_e state_q, state_d;
  logic [2:0] int_id_q, int_id_d, prio;
  logic prio_vld, take;
  logic [7:0] ovr_rd;
  logic [7:0] unused_din;
  assign unused_din = reg_din;
  irq_prio_enc #(.N(NUM_SRC)) u_prio (.req(act), .id(prio), .valid(prio_vld));
  always_comb begin
    req_d = irq_req;
    edge_v = irq_req & ~req_q;
    act = ie_q & if_q;
    take = state_q == ST_REQ && prio_vld && int_take;
    take_mask = take ? src_t'(1) << int_id_q : '0;
    ie_d = reg_wr && reg_sel == REG_IE ? reg_din[NUM_SRC-1:0] : ie_q;
    if_base = (reg_wr && reg_sel == REG_IF ? reg_din[NUM_SRC-1:0] : if_q) & ~take_mask;
    if_d = if_base | edge_v;
  end
`ifdef IRQ_CTRL_OVR_EN
  src_t ovr_q, ovr_d;
  // An edge on a bit still pending after this cycle's clears is a lost interrupt; set beats clear.
  always_comb ovr_d = (ovr_q & ~(reg_wr && reg_sel == REG_OVR ? reg_din[NUM_SRC-1:0] : '0))
                    | (edge_v & if_q & if_base);
  always_ff @(posedge clk)
    if (!rst) ovr_q <= '0;
    else ovr_q <= ovr_d;
  assign ovr_rd = 8'(ovr_q);
`else
  assign ovr_rd = 8'h00;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      req_q <= '0;
      ie_q <= '0;
      if_q <= '0;
      state_q <= ST_IDLE;
      int_id_q <= 3'd0;
    end else begin
      req_q <= req_d;
      ie_q <= ie_d;
      if_q <= if_d;
      state_q <= state_d;
      int_id_q <= int_id_d;
    end
  always_comb begin
    state_d = state_q;
    int_id_d = int_id_q;
    unique case (state_q)
      ST_IDLE: if (prio_vld) begin
        state_d = ST_REQ;
        int_id_d = prio;
      end
      ST_REQ: if (!prio_vld) state_d = ST_IDLE;
        else if (int_take) state_d = ST_ACK;
        else int_id_d = prio;
      default: state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    int_pend = state_q == ST_REQ;
    int_id = int_id_q;
    int_vec = VEC_BASE + 16'(int_id_q) * VEC_STRIDE;
    reg_dout = reg_sel == REG_IE ? 8'(ie_q) :
               reg_sel == REG_IF ? 8'(if_q) :
               reg_sel == REG_OVR ? ovr_rd : 8'h00;
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_irq_ctrl;
  localparam int NS = 5;
  localparam logic [7:0] MASK = 8'h1F;
`ifdef IRQ_CTRL_OVR_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [NS-1:0] irq_req = '0;
  logic [1:0] reg_sel = 2'd0;
  logic reg_wr = 1'b0, int_take = 1'b0;
  logic [7:0] reg_din = 8'h00, reg_dout;
  logic int_pend;
  logic [2:0] int_id;
  logic [15:0] int_vec;
  int nchk = 0, nerr = 0;
  logic [7:0] m_ie, m_if, m_ovr, m_prev;
  bit m_pend, m_ack;
  int m_id;

  irq_ctrl dut (.clk(clk), .rst(rst), .irq_req(irq_req), .reg_sel(reg_sel), .reg_wr(reg_wr),
                .reg_din(reg_din), .reg_dout(reg_dout), .int_pend(int_pend), .int_take(int_take),
                .int_id(int_id), .int_vec(int_vec));

  always #5 clk = ~clk;

  function automatic int lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] mrd(logic [1:0] s);
    return s == 2'd0 ? m_ie : s == 2'd1 ? m_if : s == 2'd2 ? m_ovr : 8'h00;
  endfunction

  function automatic logic [15:0] mvec();
    return 16'h0040 + 16'(m_id * 8);
  endfunction

  // Advance the reference by one clock using the inputs currently driven.
  task automatic model();
    logic [7:0] e, act, base, clr;
    if (!rst) begin
      m_ie = 0; m_if = 0; m_ovr = 0; m_prev = 0; m_pend = 0; m_ack = 0; m_id = 0;
      return;
    end
    e = 8'(irq_req) & ~m_prev;
    m_prev = 8'(irq_req);
    act = m_ie & m_if;
    base = (reg_wr && reg_sel == 2'd1) ? (reg_din & MASK) : m_if;
    if (m_pend && act != 0 && int_take) base[m_id] = 1'b0;
    clr = (reg_wr && reg_sel == 2'd2) ? reg_din : 8'h00;
    if (OVR) m_ovr = ((m_ovr & ~clr) | (e & m_if & base)) & MASK;
    m_if = base | e;
    if (m_ack) m_ack = 0;
    else if (m_pend) begin
      if (act == 0) m_pend = 0;
      else if (int_take) begin m_pend = 0; m_ack = 1; end
      else m_id = lowest(act);
    end else if (act != 0) begin
      m_pend = 1;
      m_id = lowest(act);
    end
    if (reg_wr && reg_sel == 2'd0) m_ie = reg_din & MASK;
  endtask

  task automatic cyc(input logic [NS-1:0] req, input bit wr = 0, input logic [1:0] sel = 0,
                     input logic [7:0] din = 0, input bit take = 0);
    irq_req = req; reg_wr = wr; reg_sel = sel; reg_din = din; int_take = take;
    model();
    @(posedge clk);
    @(negedge clk);
    reg_wr = 0; int_take = 0;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [7:0] v);
    reg_sel = sel;
    #1 v = reg_dout;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 0;
    cyc('0); cyc('0, 1, 2'd0, 8'hFF);
    nchk++; if ({int_pend, int_id, int_vec} !== {1'b0, 3'd0, 16'h0040}) begin
      nerr++; $display("FAIL reset_out got pend=%0d id=%0d vec=%h want 0 0 0040", int_pend, int_id, int_vec); end
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      nchk++; if (v !== 8'h00) begin nerr++; $display("FAIL reset_reg%0d got=%h want=00", s, v); end
    end
    rst = 1;
    cyc('0);
  endtask

  task automatic test_basic();
    logic [7:0] v;
    cyc('0, 1, 2'd0, 8'h01);
    cyc(5'h01);
    rd(2'd1, v);
    nchk++; if (v !== 8'h01) begin nerr++; $display("FAIL basic_if_set got=%h want=01", v); end
    cyc('0);
    nchk++; if ({int_pend, int_vec} !== {1'b1, 16'h0040}) begin
      nerr++; $display("FAIL basic_req got pend=%0d vec=%h want 1 0040", int_pend, int_vec); end
    cyc('0, 0, 0, 0, 1);
    rd(2'd1, v);
    nchk++; if ({v, int_pend, int_vec} !== {8'h00, 1'b0, 16'h0040}) begin
      nerr++; $display("FAIL basic_take got if=%h pend=%0d vec=%h want 00 0 0040", v, int_pend, int_vec); end
    cyc('0);
  endtask

  task automatic test_preempt();
    cyc('0, 1, 2'd0, 8'h1F);
    cyc(5'h10);
    cyc('0);
    nchk++; if ({int_pend, int_id, int_vec} !== {1'b1, 3'd4, 16'h0060}) begin
      nerr++; $display("FAIL preempt_src4 got pend=%0d id=%0d vec=%h want 1 4 0060", int_pend, int_id, int_vec); end
    cyc(5'h02);
    cyc('0);
    nchk++; if ({int_pend, int_id, int_vec} !== {1'b1, 3'd1, 16'h0048}) begin
      nerr++; $display("FAIL preempt_src1 got pend=%0d id=%0d vec=%h want 1 1 0048", int_pend, int_id, int_vec); end
    for (int k = 0; k < 6; k++) begin
      cyc('0, 0, 0, 0, int_pend);
      nchk++; if ({int_pend, int_id, int_vec} !== {m_pend, 3'(m_id), mvec()}) begin
        nerr++; $display("FAIL preempt_drain%0d got pend=%0d id=%0d vec=%h want %0d %0d %h", k, int_pend, int_id, int_vec, m_pend, m_id, mvec()); end
    end
  endtask

  task automatic test_enable_late();
    logic [7:0] v;
    cyc('0, 1, 2'd0, 8'h00);
    cyc(5'h04);
    cyc('0); cyc('0);
    rd(2'd1, v);
    nchk++; if ({v, int_pend} !== {8'h04, 1'b0}) begin
      nerr++; $display("FAIL late_masked got if=%h pend=%0d want 04 0", v, int_pend); end
    cyc('0, 1, 2'd0, 8'h04);
    cyc('0);
    nchk++; if ({int_pend, int_vec} !== {1'b1, 16'h0050}) begin
      nerr++; $display("FAIL late_enable got pend=%0d vec=%h want 1 0050", int_pend, int_vec); end
    cyc('0, 0, 0, 0, 1);
    cyc('0);
  endtask

  task automatic test_take_write_edge();
    logic [7:0] v;
    cyc('0, 1, 2'd0, 8'h01);
    cyc(5'h01);
    cyc('0);
    nchk++; if ({int_pend, int_id} !== {1'b1, 3'd0}) begin
      nerr++; $display("FAIL same_clk_setup got pend=%0d id=%0d want 1 0", int_pend, int_id); end
    cyc(5'h01, 1, 2'd1, 8'h03, 1);
    rd(2'd1, v);
    nchk++; if ({v, int_pend} !== {8'h03, 1'b0}) begin
      nerr++; $display("FAIL same_clk_if got if=%h pend=%0d want 03 0", v, int_pend); end
    cyc('0, 1, 2'd0, 8'h00);
    cyc('0, 1, 2'd1, 8'h00);
    cyc('0);
  endtask

  task automatic test_ovr();
    logic [7:0] v;
    cyc(5'h08); cyc('0); cyc(5'h08); cyc('0);
    rd(2'd2, v);
    nchk++; if (v !== m_ovr || v !== (OVR ? 8'h08 : 8'h00)) begin
      nerr++; $display("FAIL ovr_set got=%h want=%h", v, m_ovr); end
    cyc(5'h08, 1, 2'd2, 8'h08);
    rd(2'd2, v);
    nchk++; if (v !== m_ovr || v !== (OVR ? 8'h08 : 8'h00)) begin
      nerr++; $display("FAIL ovr_set_beats_clr got=%h want=%h", v, m_ovr); end
    cyc('0, 1, 2'd2, 8'hFF);
    cyc('0, 1, 2'd3, 8'hFF);
    rd(2'd2, v);
    nchk++; if (v !== 8'h00) begin nerr++; $display("FAIL ovr_clr got=%h want=00", v); end
    rd(2'd3, v);
    nchk++; if (v !== 8'h00) begin nerr++; $display("FAIL rsvd_read got=%h want=00", v); end
    cyc('0, 1, 2'd1, 8'h00);
  endtask

  task automatic test_reset_in_req();
    logic [7:0] v;
    cyc('0, 1, 2'd0, 8'h1F);
    cyc('0, 1, 2'd1, 8'h1F);
    cyc('0);
    nchk++; if (int_pend !== 1'b1) begin nerr++; $display("FAIL rst_req_setup got pend=%0d want 1", int_pend); end
    rst = 0;
    cyc(5'h1F); cyc(5'h1F);
    rd(2'd1, v);
    nchk++; if ({v, int_pend, int_id, int_vec} !== {8'h00, 1'b0, 3'd0, 16'h0040}) begin
      nerr++; $display("FAIL rst_req_out got if=%h pend=%0d id=%0d vec=%h want 00 0 0 0040", v, int_pend, int_id, int_vec); end
    rst = 1;
    cyc(5'h1F);
    rd(2'd1, v);
    nchk++; if (v !== 8'h1F) begin nerr++; $display("FAIL rst_release_fire got=%h want=1F", v); end
    cyc(5'h1F, 1, 2'd1, 8'h00);
    cyc(5'h1F); cyc(5'h1F);
    rd(2'd1, v);
    nchk++; if (v !== 8'h00) begin nerr++; $display("FAIL rst_fire_once got=%h want=00", v); end
    cyc('0);
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [1:0] s;
    for (int k = 0; k < 400; k++) begin
      cyc(NS'($urandom), $urandom_range(0, 5) == 0, 2'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);
      nchk++; if ({int_pend, int_id, int_vec} !== {m_pend, 3'(m_id), mvec()}) begin
        nerr++; $display("FAIL rand_out%0d got pend=%0d id=%0d vec=%h want %0d %0d %h", k, int_pend, int_id, int_vec, m_pend, m_id, mvec()); end
      s = 2'($urandom);
      rd(s, v);
      nchk++; if (v !== mrd(s)) begin
        nerr++; $display("FAIL rand_reg%0d sel=%0d got=%h want=%h", k, s, v, mrd(s)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preempt();
    test_enable_late();
    test_take_write_edge();
    test_ovr();
    test_reset_in_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
